apb_master: RTL and testbench

APB requester that turns a simple command/response handshake into compliant APB3 transfers (IDLE → SETUP → ACCESS) toward `apb_slave` and peers. It sits between an internal control agent (CPU bridge, test sequencer, config FSM) and the APB bus. It carries one outstanding transfer at a time and returns read data and slave error in a held response.

---
 rtl/apb_pkg.sv | 29 ++
 rtl/apb_master_if.sv | 48 ++++
 rtl/apb_wait_timer.sv | 34 +++
 rtl/apb_master.sv | 164 ++++++++++++++++
 tb/tb_apb_master.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester and its wait timer.
package apb_pkg;

  localparam int APB_ADDR_W = 2;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

  // True while a transfer owns the bus.
  function automatic logic state_busy(input apb_state_t state);
    return (state != IDLE);
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB3 bus signals seen by the requester (master)
// and by whatever sits on the other side (slave: command agent + APB completer).
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              p_sel;
  logic              p_enable;
  logic              p_write;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_w_data;
  logic              p_ready;
  logic              p_slv_err;
  logic [DATA_W-1:0] p_r_data;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output p_sel, p_enable, p_write, p_addr, p_w_data,
    input  p_ready, p_slv_err, p_r_data
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  p_sel, p_enable, p_write, p_addr, p_w_data,
    output p_ready, p_slv_err, p_r_data
  );

endinterface

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter, instantiated by apb_master only when APB_MASTER_TIMEOUT_EN
// is defined. expired fires on the wait cycle that would bring the count to TIMEOUT_CYCLES.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_r;

  // Count wait cycles; held at zero outside ACCESS so every ACCESS starts fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (tick) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = tick && (count_r == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master.sv
// APB3 requester: one outstanding command driven through SETUP/ACCESS, result held until taken.
// Optional ACCESS wait-state limit enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         p_clk,
  input  logic         p_reset,
  apb_master_if.master bus
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_word_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_word_t;

  apb_state_t state_r;
  apb_state_t state_s;
  cmd_word_t  cmd_r;
  cmd_word_t  cmd_s;
  rsp_word_t  rsp_r;
  rsp_word_t  rsp_s;
  logic       sel_r;
  logic       sel_s;
  logic       enable_r;
  logic       enable_s;
  logic       rsp_valid_r;
  logic       rsp_valid_s;
  logic       cmd_ready_s;
  logic       cmd_fire_s;
  logic       rsp_fire_s;
  logic       expired_s;

  // A new command is only taken with the bus idle and no unread response.
  assign cmd_ready_s = !state_busy(state_r) && !rsp_valid_r && !p_reset;
  assign cmd_fire_s  = bus.cmd_valid && cmd_ready_s;
  assign rsp_fire_s  = rsp_valid_r && bus.rsp_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  logic wait_clear_s;
  logic wait_tick_s;

  assign wait_clear_s = (state_r != ACCESS);
  assign wait_tick_s  = (state_r == ACCESS) && !bus.p_ready;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (p_clk),
    .reset  (p_reset),
    .clear  (wait_clear_s),
    .tick   (wait_tick_s),
    .expired(expired_s)
  );
`else
  assign expired_s = 1'b0;
`endif

  // Next-state, bus control and response decode.
  always_comb begin
    state_s  = state_r;
    cmd_s    = cmd_r;
    rsp_s    = rsp_r;
    sel_s    = sel_r;
    enable_s = enable_r;
    if (rsp_fire_s) begin
      rsp_valid_s = 1'b0;
    end else begin
      rsp_valid_s = rsp_valid_r;
    end

    case (state_r)
      IDLE: begin
        if (cmd_fire_s) begin
          state_s     = SETUP;
          sel_s       = 1'b1;
          enable_s    = 1'b0;
          cmd_s.write = bus.cmd_write;
          cmd_s.addr  = bus.cmd_addr;
          if (bus.cmd_write) begin
            cmd_s.wdata = bus.cmd_wdata;
          end else begin
            cmd_s.wdata = '0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        state_s  = ACCESS;
        sel_s    = 1'b1;
        enable_s = 1'b1;
      end
      ACCESS: begin
        // A completion on the expiry edge wins over the timeout.
        if (bus.p_ready) begin
          state_s     = IDLE;
          sel_s       = 1'b0;
          enable_s    = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_s.err   = bus.p_slv_err;
          if (cmd_r.write) begin
            rsp_s.rdata = '0;
          end else begin
            rsp_s.rdata = bus.p_r_data;
          end
        end else if (expired_s) begin
          state_s     = IDLE;
          sel_s       = 1'b0;
          enable_s    = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_s.err   = 1'b1;
          rsp_s.rdata = '0;
        end else begin
          state_s = ACCESS;
        end
      end
      default: begin
        state_s  = IDLE;
        sel_s    = 1'b0;
        enable_s = 1'b0;
      end
    endcase
  end

  // State, bus and response registers; reset abandons any transfer and response.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      state_r     <= IDLE;
      cmd_r       <= '0;
      rsp_r       <= '0;
      sel_r       <= 1'b0;
      enable_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_r       <= cmd_s;
      rsp_r       <= rsp_s;
      sel_r       <= sel_s;
      enable_r    <= enable_s;
      rsp_valid_r <= rsp_valid_s;
    end
  end

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.p_sel     = sel_r;
  assign bus.p_enable  = enable_r;
  assign bus.p_write   = cmd_r.write;
  assign bus.p_addr    = cmd_r.addr;
  assign bus.p_w_data  = cmd_r.wdata;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_r.rdata;
  assign bus.rsp_err   = rsp_r.err;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized transfers
// checked against a latency/result model derived from the transfer rules.
module tb_apb_master;

  localparam int TO_CYC = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  apb_master_if #(.ADDR_W(2), .DATA_W(32)) bus ();

  apb_master #(
    .ADDR_W(2),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .p_clk  (clk),
    .p_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Reference model: handshake at edge N, response visible N+3+waits, or N+2+limit on timeout.
  function automatic bit model_timed_out(input int waits);
    return TO_EN && (waits >= TO_CYC);
  endfunction

  function automatic int model_lat(input int waits);
    if (model_timed_out(waits)) return 2 + TO_CYC;
    return 3 + waits;
  endfunction

  function automatic logic model_err(input int waits, input logic err);
    if (model_timed_out(waits)) return 1'b1;
    return err;
  endfunction

  function automatic logic [31:0] model_rdata(input logic wr, input int waits, input logic [31:0] rdata);
    if (wr || model_timed_out(waits)) return 32'd0;
    return rdata;
  endfunction

  function automatic logic [71:0] out_snap();
    return {bus.p_sel, bus.p_enable, bus.p_write, bus.p_addr, bus.p_w_data,
            bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.cmd_ready};
  endfunction

  // Drives one transfer from a negedge with cmd_ready expected; counts protocol deviations.
  task automatic run_xfer(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] rdata, input logic err,
                          input int rsp_delay, input logic keep_ready,
                          output int lat, output int viol, output logic [31:0] got_rdata,
                          output logic got_err, output int setup_cyc);
    logic [31:0] exp_wd;
    int guard;
    int i;
    viol = 0; lat = 0; got_rdata = 32'd0; got_err = 1'b0; setup_cyc = -1;
    exp_wd = wr ? wdata : 32'd0;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) viol++;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
    @(negedge clk);
    lat = 1;
    setup_cyc = cyc;
    bus.cmd_valid = 1'($urandom); bus.cmd_write = 1'($urandom);
    bus.cmd_addr = 2'($urandom); bus.cmd_wdata = $urandom;
    if (bus.p_sel !== 1'b1 || bus.p_enable !== 1'b0 || bus.p_addr !== addr || bus.p_write !== wr ||
        bus.p_w_data !== exp_wd || bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) viol++;
    bus.p_ready = 1'($urandom); bus.p_slv_err = 1'($urandom); bus.p_r_data = $urandom;
    @(negedge clk);
    lat = 2;
    i = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 60) begin
      if (bus.p_sel !== 1'b1 || bus.p_enable !== 1'b1 || bus.p_addr !== addr || bus.p_write !== wr ||
          bus.p_w_data !== exp_wd || bus.cmd_ready !== 1'b0) viol++;
      if (i >= waits) begin
        bus.p_ready = 1'b1; bus.p_slv_err = err; bus.p_r_data = rdata;
      end else begin
        bus.p_ready = 1'b0; bus.p_slv_err = 1'($urandom); bus.p_r_data = $urandom;
      end
      i++;
      @(negedge clk);
      lat++;
    end
    if (bus.rsp_valid !== 1'b1) viol++;
    bus.p_ready = 1'($urandom); bus.p_slv_err = 1'($urandom); bus.p_r_data = $urandom;
    if (bus.p_sel !== 1'b0 || bus.p_enable !== 1'b0 || bus.p_addr !== addr || bus.p_write !== wr ||
        bus.p_w_data !== exp_wd || bus.cmd_ready !== 1'b0) viol++;
    got_rdata = bus.rsp_rdata;
    got_err = bus.rsp_err;
    for (int d = 0; d < rsp_delay; d++) begin
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== got_rdata || bus.rsp_err !== got_err ||
          bus.cmd_ready !== 1'b0 || bus.p_sel !== 1'b0) viol++;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) viol++;
    if (!keep_ready) bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.p_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [71:0] snap;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    snap = out_snap();
    total++;
    if (snap !== 72'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", snap); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", bus.cmd_ready); end
    // Abandon a read stuck in ACCESS.
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 2'd3; bus.p_ready = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.p_sel, bus.p_enable} !== 2'b11) begin bad++; $display("FAIL reset_pre_access got=%b want=11", {bus.p_sel, bus.p_enable}); end
    rst = 1'b1; bus.p_ready = 1'b1; bus.p_r_data = 32'h1234_5678;
    repeat (2) @(negedge clk);
    snap = out_snap();
    total++;
    if (snap !== 72'd0) begin bad++; $display("FAIL reset_mid_outputs got=%h want=0", snap); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.p_sel} !== 3'b100) begin
      bad++; $display("FAIL reset_mid_release got=%b want=100", {bus.cmd_ready, bus.rsp_valid, bus.p_sel});
    end
    repeat (3) @(negedge clk);
    total++;
    if ({bus.rsp_valid, bus.p_sel} !== 2'b00) begin bad++; $display("FAIL reset_no_rsp got=%b want=00", {bus.rsp_valid, bus.p_sel}); end
    bus.p_ready = 1'b0;
    // Pending response is dropped by reset.
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 2'd1; bus.cmd_wdata = 32'd7; bus.p_ready = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL reset_pend_pre got=%b want=1", bus.rsp_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.p_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin bad++; $display("FAIL reset_pend_drop got=%b want=01", {bus.rsp_valid, bus.cmd_ready}); end
  endtask

  task automatic test_write_zero_wait();
    int lat, viol, sc;
    logic [31:0] rd;
    logic er;
    run_xfer(1'b1, 2'b10, 32'd16, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, lat, viol, rd, er, sc);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL wr_lat got=%0d want=3", lat); end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL wr_protocol got=%0d want=0", viol); end
    total++;
    if ({rd, er} !== 33'd0) begin bad++; $display("FAIL wr_rsp got=%h/%b want=0/0", rd, er); end
  endtask

  task automatic test_read_wait_states();
    int lat, viol, sc;
    logic [31:0] rd;
    logic er;
    run_xfer(1'b0, 2'b10, 32'hFFFF_0000, 3, 32'd16, 1'b0, 0, 1'b0, lat, viol, rd, er, sc);
    total++;
    if (lat !== 6) begin bad++; $display("FAIL rd_wait_lat got=%0d want=6", lat); end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL rd_wait_protocol got=%0d want=0", viol); end
    total++;
    if (rd !== 32'd16 || er !== 1'b0) begin bad++; $display("FAIL rd_wait_rsp got=%0d/%b want=16/0", rd, er); end
  endtask

  task automatic test_slverr_backpressure();
    int lat, viol, sc;
    logic [31:0] rd;
    logic er;
    run_xfer(1'b0, 2'b01, 32'd0, 1, 32'hA5A5_0F0F, 1'b1, 5, 1'b0, lat, viol, rd, er, sc);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL err_lat got=%0d want=4", lat); end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL err_hold got=%0d want=0", viol); end
    total++;
    if (er !== 1'b1 || rd !== 32'hA5A5_0F0F) begin bad++; $display("FAIL err_rsp got=%h/%b want=a5a50f0f/1", rd, er); end
  endtask

  task automatic test_back_to_back();
    int lat1, viol1, sc1, lat2, viol2, sc2;
    logic [31:0] rd1, rd2;
    logic er1, er2;
    bus.rsp_ready = 1'b1;
    run_xfer(1'b1, 2'd0, 32'd20, 0, 32'd0, 1'b0, 0, 1'b1, lat1, viol1, rd1, er1, sc1);
    run_xfer(1'b1, 2'd1, 32'd22, 0, 32'd0, 1'b0, 0, 1'b0, lat2, viol2, rd2, er2, sc2);
    total++;
    if (sc2 - sc1 !== 4) begin bad++; $display("FAIL b2b_spacing got=%0d want=4", sc2 - sc1); end
    total++;
    if (viol1 + viol2 !== 0) begin bad++; $display("FAIL b2b_protocol got=%0d want=0", viol1 + viol2); end
    total++;
    if (lat1 !== 3 || lat2 !== 3) begin bad++; $display("FAIL b2b_lat got=%0d,%0d want=3,3", lat1, lat2); end
  endtask

  task automatic test_long_access();
    int lat, viol, sc;
    logic [31:0] rd;
    logic er;
`ifdef APB_MASTER_TIMEOUT_EN
    run_xfer(1'b0, 2'd2, 32'd0, 50, 32'h0BAD_F00D, 1'b0, 0, 1'b0, lat, viol, rd, er, sc);
    total++;
    if (lat !== 2 + TO_CYC) begin bad++; $display("FAIL to_abort_lat got=%0d want=%0d", lat, 2 + TO_CYC); end
    total++;
    if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL to_abort_rsp got=%h/%b want=0/1", rd, er); end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL to_abort_protocol got=%0d want=0", viol); end
    run_xfer(1'b0, 2'd2, 32'd0, TO_CYC - 1, 32'h0000_C0DE, 1'b0, 0, 1'b0, lat, viol, rd, er, sc);
    total++;
    if (lat !== 2 + TO_CYC) begin bad++; $display("FAIL to_edge_lat got=%0d want=%0d", lat, 2 + TO_CYC); end
    total++;
    if (er !== 1'b0 || rd !== 32'h0000_C0DE) begin bad++; $display("FAIL to_edge_rsp got=%h/%b want=0000c0de/0", rd, er); end
`else
    run_xfer(1'b0, 2'd2, 32'd0, 20, 32'h0BAD_F00D, 1'b0, 0, 1'b0, lat, viol, rd, er, sc);
    total++;
    if (lat !== 23) begin bad++; $display("FAIL long_wait_lat got=%0d want=23", lat); end
    total++;
    if (er !== 1'b0 || rd !== 32'h0BAD_F00D) begin bad++; $display("FAIL long_wait_rsp got=%h/%b want=0badf00d/0", rd, er); end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL long_wait_protocol got=%0d want=0", viol); end
`endif
  endtask

  task automatic test_random();
    int lat, viol, sc, waits, dly;
    logic [31:0] rd, wd, rdat;
    logic er, wr, serr;
    logic [1:0] addr;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom); addr = 2'($urandom); wd = $urandom; rdat = $urandom; serr = 1'($urandom);
      waits = $urandom_range(0, 6);
      dly = $urandom_range(0, 3);
      run_xfer(wr, addr, wd, waits, rdat, serr, dly, 1'b0, lat, viol, rd, er, sc);
      total++;
      if (lat !== model_lat(waits) || viol !== 0) begin
        bad++; $display("FAIL rnd%0d_timing got=%0d/%0d want=%0d/0", n, lat, viol, model_lat(waits));
      end
      total++;
      if (rd !== model_rdata(wr, waits, rdat) || er !== model_err(waits, serr)) begin
        bad++; $display("FAIL rnd%0d_rsp got=%h/%b want=%h/%b", n, rd, er, model_rdata(wr, waits, rdat), model_err(waits, serr));
      end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 2'd0; bus.cmd_wdata = 32'd0;
    bus.rsp_ready = 1'b0; bus.p_ready = 1'b0; bus.p_slv_err = 1'b0; bus.p_r_data = 32'd0;
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_slverr_backpressure();
    test_back_to_back();
    test_long_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
